ytydla_cmac_accu_ctrl: RTL and testbench
========================================

Name: ytydla_cmac_accu_ctrl

Overview:
Sequencer for the CMAC 64-lane accumulation tree. It accepts a job of N passes and releases one 64-lane vector at a time into the tree. It waits for the tree's aggregation result, then sums the per-pass aggregations into one job result. It delivers that result downstream over a valid/ready handshake. Only one pass is in the tree at any time, because the tree's IDLE/CAL/VLD sequencing does not overlap passes.

Parameters:
DATA_W, 32, width of aggregation and result; equals YTYDLA_DATA_LENGTH.
PASS_W, 8, width of the pass-count field.

Ports:
ytydla_core_clk  input  1  core clock, rising edge.
ytydla_core_rst_n  input  1  asynchronous active-low reset.
job_valid  input  1  job request.
job_ready  output  1  controller can accept a job.
job_passes  input  PASS_W  passes in the job; sampled on job handshake.
cmac_data_valid  input  1  upstream has a 64-lane vector on the tree inputs.
cmac_data_ready  output  1  controller releases the vector to the tree.
ctrl2accu_valid  output  1  one-cycle start pulse to the tree (cmac2accu_valid).
accu2ctrl_valid  input  1  tree result strobe (accu2cmac_valid).
accu2ctrl_aggregation  input  DATA_W  tree result (accu2cmac_aggregation).
result_valid  output  1  job result available.
result_data  output  DATA_W  job sum.
result_ready  input  1  downstream accepts the result.
busy  output  1  state is not IDLE.
err_unexp  output  1  sticky flag: tree result arrived outside WAIT.

Clock and reset:
- One clock, ytydla_core_clk.
- Reset ytydla_core_rst_n is asynchronous, active-low.
- All flops reset asynchronously.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset values: state IDLE; sum 0; pass_cnt 0; passes_q 0; err_unexp 0.
- Output values at reset (follow from state IDLE): job_ready 1; cmac_data_ready 0; ctrl2accu_valid 0; result_valid 0; result_data 0; busy 0.
- IDLE:
  - job_ready=1.
  - On job_valid, the job is accepted: passes_q <= (job_passes==0 ? 1 : job_passes), sum <= 0, pass_cnt <= 0, go to ISSUE.
- ISSUE:
  - cmac_data_ready=1.
  - On cmac_data_valid, ctrl2accu_valid=1 in that same cycle (combinational AND of state, cmac_data_valid), then go to WAIT.
  - ctrl2accu_valid is never high for more than one cycle per pass.
- WAIT:
  - No outputs asserted.
  - On accu2ctrl_valid: sum <= sum + accu2ctrl_aggregation, wrapping modulo 2^DATA_W; pass_cnt <= pass_cnt + 1.
  - If pass_cnt == passes_q-1, go to DONE; otherwise go to ISSUE.
  - The next ISSUE may hand-shake in the very next cycle.
  - No timeout; the controller waits indefinitely.
- DONE:
  - result_valid=1 and result_data=sum; both held stable until result_ready.
  - On result_ready, go to IDLE.
  - job_ready becomes 1 in the following cycle, not in the same cycle.
- result_data: always drives sum; it is only meaningful while result_valid=1.
- err_unexp:
  - Set when accu2ctrl_valid=1 in any state other than WAIT; that strobe is otherwise ignored (no sum update).
  - Cleared only by reset.
- Latency: job accept → first ctrl2accu_valid ≥1 cycle. Last tree strobe → result_valid exactly 1 cycle.
- Pass counter: pass_cnt is PASS_W bits; passes_q=255 is legal and completes without wrap.
- Reset mid-job: the job is abandoned and all state returns to reset values. A tree result still in flight after reset lands in IDLE and sets err_unexp.

Optional Feature:
Macro YTYDLA_CMAC_ACCU_CTRL_SAT_EN.
- Defined: the sum treats operands as two's-complement signed. On overflow it saturates to 2^(DATA_W-1)-1 (positive overflow) or -2^(DATA_W-1) (negative overflow). Saturation is applied at each pass; a saturated sum can move back toward zero on later passes.
- Undefined: plain wrapping add modulo 2^DATA_W, with no extra logic.

Test Plan:
- Reset, then job passes=3, tree returns 10, 20, 30 → exactly three ctrl2accu_valid pulses; result_valid one cycle after the third strobe; result_data=60.
- job passes=0, tree returns 7 → treated as one pass; result_data=7.
- result_ready held 0 for 5 cycles in DONE → result_valid and result_data=60 stable throughout; job_ready=0 until the cycle after the handshake.
- cmac_data_valid low for 4 cycles in ISSUE → no ctrl2accu_valid pulse; cmac_data_ready held 1; continues normally once valid rises.
- accu2ctrl_valid pulsed in IDLE with aggregation 99 → err_unexp=1; the next job's sum excludes 99. Reset asserted mid-WAIT → all outputs at reset values; job_ready=1.
- DATA_W=32, passes=2, tree returns 0x7FFFFFFF then 1 → result_data=0x80000000 without the macro; 0x7FFFFFFF with YTYDLA_CMAC_ACCU_CTRL_SAT_EN.

Source files
------------

// File: rtl/ytydla_cmac_accu_ctrl.sv
// CMAC accumulation-tree sequencer: issues one pass at a time, sums tree results.
// Optional YTYDLA_CMAC_ACCU_CTRL_SAT_EN selects a signed saturating job sum.
module ytydla_cmac_accu_ctrl #(
  parameter int DATA_W = 32,
  parameter int PASS_W = 8
) (
  input  logic              ytydla_core_clk,
  input  logic              ytydla_core_rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [PASS_W-1:0] job_passes,
  input  logic              cmac_data_valid,
  output logic              cmac_data_ready,
  output logic              ctrl2accu_valid,
  input  logic              accu2ctrl_valid,
  input  logic [DATA_W-1:0] accu2ctrl_aggregation,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  input  logic              result_ready,
  output logic              busy,
  output logic              err_unexp
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_sum;
  logic [PASS_W-1:0]   r_pass_cnt;
  logic [PASS_W-1:0]   r_passes_q;
  logic                r_err;
  logic [DATA_W-1:0]   w_sum_nxt;
  logic                w_accept;
  logic                w_strobe;
  logic                w_last;

  assign w_accept = (r_state == IDLE) && job_valid;
  assign w_strobe = (r_state == WAIT) && accu2ctrl_valid;
  assign w_last   = (r_pass_cnt == (r_passes_q - PASS_W'(1)));

`ifdef YTYDLA_CMAC_ACCU_CTRL_SAT_EN
  logic [DATA_W-1:0] w_add;
  logic              w_ovf;
  assign w_add = r_sum + accu2ctrl_aggregation;
  // Overflow only when both operands share a sign the result lacks.
  assign w_ovf = (r_sum[DATA_W-1] == accu2ctrl_aggregation[DATA_W-1]) &&
                 (w_add[DATA_W-1] != r_sum[DATA_W-1]);
  assign w_sum_nxt = !w_ovf ? w_add :
                     r_sum[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                       {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign w_sum_nxt = r_sum + accu2ctrl_aggregation;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    job_ready       = 1'b0;
    cmac_data_ready = 1'b0;
    ctrl2accu_valid = 1'b0;
    result_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        cmac_data_ready = 1'b1;
        ctrl2accu_valid = cmac_data_valid;
        if (cmac_data_valid) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (accu2ctrl_valid) w_state_nxt = w_last ? DONE : ISSUE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ytydla_core_clk or negedge ytydla_core_rst_n) begin
    if (!ytydla_core_rst_n) begin
      r_state    <= IDLE;
      r_sum      <= '0;
      r_pass_cnt <= '0;
      r_passes_q <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_passes_q <= (job_passes == '0) ? PASS_W'(1) : job_passes;
        r_sum      <= '0;
        r_pass_cnt <= '0;
      end
      if (w_strobe) begin
        r_sum      <= w_sum_nxt;
        r_pass_cnt <= r_pass_cnt + PASS_W'(1);
      end
      if (accu2ctrl_valid && (r_state != WAIT)) r_err <= 1'b1;
    end
  end

  assign result_data = r_sum;
  assign busy        = (r_state != IDLE);
  assign err_unexp   = r_err;

endmodule

// File: tb/tb_ytydla_cmac_accu_ctrl.sv
// Scoreboard bench for ytydla_cmac_accu_ctrl.
// Follows YTYDLA_CMAC_ACCU_CTRL_SAT_EN for the expected job sums.
module tb_ytydla_cmac_accu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [7:0]  job_passes;
  logic        cmac_data_valid;
  logic        cmac_data_ready;
  logic        ctrl2accu_valid;
  logic        accu2ctrl_valid;
  logic [31:0] accu2ctrl_aggregation;
  logic        result_valid;
  logic [31:0] result_data;
  logic        result_ready;
  logic        busy;
  logic        err_unexp;

  int          n_chk;
  int          n_err;
  int          pulses;
  logic [31:0] sb[$];
  logic [31:0] agg_q[$];

  ytydla_cmac_accu_ctrl #(.DATA_W(32), .PASS_W(8)) dut (
    .ytydla_core_clk       (clk),
    .ytydla_core_rst_n     (rst_n),
    .job_valid             (job_valid),
    .job_ready             (job_ready),
    .job_passes            (job_passes),
    .cmac_data_valid       (cmac_data_valid),
    .cmac_data_ready       (cmac_data_ready),
    .ctrl2accu_valid       (ctrl2accu_valid),
    .accu2ctrl_valid       (accu2ctrl_valid),
    .accu2ctrl_aggregation (accu2ctrl_aggregation),
    .result_valid          (result_valid),
    .result_data           (result_data),
    .result_ready          (result_ready),
    .busy                  (busy),
    .err_unexp             (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ctrl2accu_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] acc_model(input logic [31:0] a,
                                            input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef YTYDLA_CMAC_ACCU_CTRL_SAT_EN
    if (s > 64'sd2147483647) return 32'h7fff_ffff;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  task automatic run_job(input logic [7:0] p, input int stall,
                         input int hold, input int gap);
    int n;
    logic [31:0] e;
    n = (p == 0) ? 1 : int'(p);
    e = '0;
    for (int i = 0; i < n; i++) e = acc_model(e, agg_q[i]);
    sb.push_back(e);
    @(negedge clk);
    chk("job_ready_idle", {31'd0, job_ready}, 32'd1);
    job_valid  = 1'b1;
    job_passes = p;
    @(negedge clk);
    job_valid = 1'b0;
    pulses    = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        for (int s = 0; s < stall; s++) begin
          #1;
          chk("stall_dready", {31'd0, cmac_data_ready}, 32'd1);
          chk("stall_nopulse", {31'd0, ctrl2accu_valid}, 32'd0);
          @(negedge clk);
        end
      end
      cmac_data_valid = 1'b1;
      #1 chk("pulse", {31'd0, ctrl2accu_valid}, 32'd1);
      @(negedge clk);
      cmac_data_valid = 1'b1;
      #1 chk("wait_nopulse", {31'd0, ctrl2accu_valid}, 32'd0);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      cmac_data_valid = 1'b0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      accu2ctrl_valid       = 1'b1;
      accu2ctrl_aggregation = agg_q[i];
      @(negedge clk);
      accu2ctrl_valid = 1'b0;
      #1;
      if (i == n - 1)
        chk("rvalid_lat", {31'd0, result_valid}, 32'd1);
      else
        chk("reissue", {31'd0, cmac_data_ready}, 32'd1);
    end
    chk("pulses", pulses, n);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", {31'd0, result_valid}, 32'd1);
      chk("hold_data", result_data, sb[0]);
      chk("hold_jready", {31'd0, job_ready}, 32'd0);
      @(negedge clk);
    end
    result_ready = 1'b1;
    #1 chk("hs_jready", {31'd0, job_ready}, 32'd0);
    chk("hs_valid", {31'd0, result_valid}, 32'd1);
    chk("result", result_data, sb.pop_front());
    @(negedge clk);
    result_ready = 1'b0;
    #1 chk("post_jready", {31'd0, job_ready}, 32'd1);
    chk("post_valid", {31'd0, result_valid}, 32'd0);
    agg_q.delete();
  endtask

  task automatic chk_reset_outs();
    chk("rst_jready", {31'd0, job_ready}, 32'd1);
    chk("rst_dready", {31'd0, cmac_data_ready}, 32'd0);
    chk("rst_pulse", {31'd0, ctrl2accu_valid}, 32'd0);
    chk("rst_rvalid", {31'd0, result_valid}, 32'd0);
    chk("rst_rdata", result_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    pulses = 0;
    rst_n = 1'b0;
    job_valid = 1'b0;
    job_passes = '0;
    cmac_data_valid = 1'b0;
    accu2ctrl_valid = 1'b0;
    accu2ctrl_aggregation = '0;
    result_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outs();
    chk("rst_err", {31'd0, err_unexp}, 32'd0);
    rst_n = 1'b1;

    agg_q = '{32'd10, 32'd20, 32'd30};
    run_job(8'd3, 0, 0, 0);
    agg_q = '{32'd7};
    run_job(8'd0, 0, 0, 1);
    agg_q = '{32'd10, 32'd20, 32'd30};
    run_job(8'd3, 0, 5, 2);
    agg_q = '{32'd4, 32'd5};
    run_job(8'd2, 4, 0, 0);

    @(negedge clk);
    accu2ctrl_valid       = 1'b1;
    accu2ctrl_aggregation = 32'd99;
    @(negedge clk);
    accu2ctrl_valid = 1'b0;
    #1 chk("err_idle", {31'd0, err_unexp}, 32'd1);
    agg_q = '{32'd5, 32'd6};
    run_job(8'd2, 0, 0, 0);
    chk("err_sticky", {31'd0, err_unexp}, 32'd1);

    agg_q = '{32'h7fff_ffff, 32'd1};
    run_job(8'd2, 0, 0, 0);
    agg_q = '{32'h8000_0000, 32'hffff_ffff, 32'd5};
    run_job(8'd3, 0, 0, 0);
    agg_q = '{32'hffff_ffff, 32'd2};
    run_job(8'd2, 0, 1, 0);
    for (int i = 0; i < 255; i++) agg_q.push_back(32'(i));
    run_job(8'd255, 0, 0, 0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst2_err", {31'd0, err_unexp}, 32'd0);
    @(negedge clk);
    job_valid  = 1'b1;
    job_passes = 8'd2;
    @(negedge clk);
    job_valid       = 1'b0;
    cmac_data_valid = 1'b1;
    @(negedge clk);
    cmac_data_valid = 1'b0;
    #1 chk("midwait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    accu2ctrl_valid       = 1'b1;
    accu2ctrl_aggregation = 32'd3;
    @(negedge clk);
    accu2ctrl_valid = 1'b0;
    #1 chk("inflight_err", {31'd0, err_unexp}, 32'd1);
    chk("inflight_jready", {31'd0, job_ready}, 32'd1);
    chk("inflight_rdata", result_data, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
